dm_store_buffer: RTL and testbench

- Posted-write store buffer between the CPU data-memory port and the data SRAM wrapper.
- Stores are queued in a FIFO and drained to SRAM in cycles where no load is using the port, so stores never stall the CPU unless the buffer is full.
- Loads go straight to SRAM. A load to a word with a pending store stalls until that store has drained, so read-after-write ordering is preserved.

---
 rtl/dm_store_buffer_if.sv | 74 +++++++
 rtl/dm_store_buffer.sv | 194 +++++++++++++++++++
 tb/tb_dm_store_buffer.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_store_buffer_if.sv
// -----------------------------------------------------------------------------
// dm_store_buffer_if
//
// Bundles the CPU data-memory request/response signals and the data-SRAM
// port of the posted-write store buffer.
//
//   CPU side    : cpu_req_valid, cpu_req_we, cpu_req_web, cpu_req_addr,
//                 cpu_req_wdata, drain_req  (towards the buffer)
//                 cpu_stall, cpu_rdata, cpu_rvalid, sb_empty (from the buffer)
//   SRAM side   : DM_CS, DM_OE, DM_WEB, DM_A, DM_DI (from the buffer)
//                 DM_DO (towards the buffer)
//
// Modports:
//   slave  - the store buffer itself
//   master - the environment (CPU + SRAM wrapper, or a testbench)
// -----------------------------------------------------------------------------
interface dm_store_buffer_if #(
    parameter int AW = 14
);
    logic          cpu_req_valid;
    logic          cpu_req_we;
    logic [3:0]    cpu_req_web;
    logic [31:0]   cpu_req_addr;
    logic [31:0]   cpu_req_wdata;
    logic          cpu_stall;
    logic [31:0]   cpu_rdata;
    logic          cpu_rvalid;
    logic          drain_req;
    logic          sb_empty;
    logic          DM_CS;
    logic          DM_OE;
    logic [3:0]    DM_WEB;
    logic [AW-1:0] DM_A;
    logic [31:0]   DM_DI;
    logic [31:0]   DM_DO;

    modport slave (
        input  cpu_req_valid,
        input  cpu_req_we,
        input  cpu_req_web,
        input  cpu_req_addr,
        input  cpu_req_wdata,
        input  drain_req,
        input  DM_DO,
        output cpu_stall,
        output cpu_rdata,
        output cpu_rvalid,
        output sb_empty,
        output DM_CS,
        output DM_OE,
        output DM_WEB,
        output DM_A,
        output DM_DI
    );

    modport master (
        output cpu_req_valid,
        output cpu_req_we,
        output cpu_req_web,
        output cpu_req_addr,
        output cpu_req_wdata,
        output drain_req,
        output DM_DO,
        input  cpu_stall,
        input  cpu_rdata,
        input  cpu_rvalid,
        input  sb_empty,
        input  DM_CS,
        input  DM_OE,
        input  DM_WEB,
        input  DM_A,
        input  DM_DI
    );
endinterface

// File: rtl/dm_store_buffer.sv
// -----------------------------------------------------------------------------
// dm_store_buffer
//
// Posted-write store buffer between the CPU data-memory port and the data
// SRAM wrapper. Stores are queued in a circular FIFO and drained to SRAM in
// any cycle where no load owns the single SRAM port. Loads go straight to
// SRAM; a load whose word matches a pending store stalls until that store
// has drained, which preserves read-after-write ordering without forwarding.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset; discards pending stores
//   bus  - dm_store_buffer_if.slave: CPU request/response + SRAM port
//
// Parameters:
//   DEPTH - number of store entries (power of two, >= 2)
//   AW    - SRAM word-address width; word address = byte address [AW+1:2]
// -----------------------------------------------------------------------------
module dm_store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 14
) (
    input  logic             clk,
    input  logic             rst,
    dm_store_buffer_if.slave bus
);
    localparam int            PW      = $clog2(DEPTH);
    localparam int            CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Entry storage
    logic [AW-1:0] ent_addr_r [DEPTH];
    logic [3:0]    ent_web_r  [DEPTH];
    logic [31:0]   ent_data_r [DEPTH];
    logic [DEPTH-1:0] valid_r;

    // FIFO bookkeeping; pointers wrap naturally because DEPTH is a power of two
    logic [PW-1:0] head_r;
    logic [PW-1:0] tail_r;
    logic [CW-1:0] count_r;

    // Load return path
    logic          rvalid_r;
    logic [31:0]   rdata_r;

    // Request classification
    logic [AW-1:0] req_word_s;
    logic          full_s;
    logic          empty_s;
    logic          fence_s;
    logic          hit_s;
    logic          is_load_s;
    logic          is_store_s;
    logic          noop_s;
    logic          stall_s;
    logic          load_go_s;
    logic          enq_s;
    logic          pop_s;

    // SRAM port drive
    logic          dm_cs_s;
    logic          dm_oe_s;
    logic [3:0]    dm_web_s;
    logic [AW-1:0] dm_a_s;
    logic [31:0]   dm_di_s;

    // Byte-offset and upper address bits do not select an SRAM word
    logic          unused_addr_s;
    assign unused_addr_s = ^{bus.cpu_req_addr[31:AW+2], bus.cpu_req_addr[1:0]};

    assign req_word_s = bus.cpu_req_addr[AW+1:2];
    assign full_s     = (count_r == DEPTH_C);
    assign empty_s    = (count_r == {CW{1'b0}});
    assign fence_s    = bus.drain_req & ~empty_s;
    assign is_load_s  = bus.cpu_req_valid & ~bus.cpu_req_we;
    assign is_store_s = bus.cpu_req_valid &  bus.cpu_req_we;
    // A store with every byte disabled writes nothing, so it is never queued
    assign noop_s     = (bus.cpu_req_web == 4'b1111);

    // Load address match against every valid pending store
    always_comb begin
        hit_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            hit_s = hit_s | (valid_r[i] & (ent_addr_r[i] == req_word_s));
        end
    end

    // Stall and acceptance; everything is gated off while reset is asserted.
    // A full buffer stalls a store even if the head pops this cycle.
    assign stall_s   = rst & bus.cpu_req_valid &
                       (fence_s | (is_store_s & full_s) | (is_load_s & hit_s));
    assign load_go_s = rst & is_load_s & ~stall_s;
    assign enq_s     = rst & is_store_s & ~stall_s & ~noop_s;
    // Drain whenever the port is not claimed by an accepted load; a stalled
    // load leaves the port free so the hazard it waits on can clear.
    assign pop_s     = rst & ~load_go_s & ~empty_s;

    // SRAM port arbitration: accepted load first, then head drain, else idle
    always_comb begin
        dm_cs_s  = 1'b0;
        dm_oe_s  = 1'b0;
        dm_web_s = 4'b1111;
        dm_a_s   = {AW{1'b0}};
        dm_di_s  = 32'h0000_0000;
        if (load_go_s) begin
            dm_cs_s  = 1'b1;
            dm_oe_s  = 1'b1;
            dm_web_s = 4'b1111;
            dm_a_s   = req_word_s;
            dm_di_s  = 32'h0000_0000;
        end else if (pop_s) begin
            dm_cs_s  = 1'b1;
            dm_oe_s  = 1'b0;
            dm_web_s = ent_web_r[head_r];
            dm_a_s   = ent_addr_r[head_r];
            dm_di_s  = ent_data_r[head_r];
        end else begin
            dm_cs_s  = 1'b0;
            dm_oe_s  = 1'b0;
            dm_web_s = 4'b1111;
            dm_a_s   = {AW{1'b0}};
            dm_di_s  = 32'h0000_0000;
        end
    end

    // Entry array: write at tail on enqueue, invalidate head on pop.
    // Tail and head never name the same slot in one cycle: that would need
    // count == 0 (no pop) or count == DEPTH (store stalls).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                ent_addr_r[i] <= {AW{1'b0}};
                ent_web_r[i]  <= 4'b1111;
                ent_data_r[i] <= 32'h0000_0000;
            end
        end else begin
            if (enq_s) begin
                valid_r[tail_r]    <= 1'b1;
                ent_addr_r[tail_r] <= req_word_s;
                ent_web_r[tail_r]  <= bus.cpu_req_web;
                ent_data_r[tail_r] <= bus.cpu_req_wdata;
            end
            if (pop_s) begin
                valid_r[head_r] <= 1'b0;
            end
        end
    end

    // Head/tail pointers and occupancy count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_r  <= {PW{1'b0}};
            tail_r  <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
        end else begin
            if (enq_s) begin
                tail_r <= tail_r + PW'(1);
            end
            if (pop_s) begin
                head_r <= head_r + PW'(1);
            end
            case ({enq_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Load return: rvalid follows an accepted load by one cycle; the SRAM
    // data of that cycle is captured so cpu_rdata holds until the next load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rvalid_r <= 1'b0;
            rdata_r  <= 32'h0000_0000;
        end else begin
            rvalid_r <= load_go_s;
            rdata_r  <= rvalid_r ? bus.DM_DO : rdata_r;
        end
    end

    assign bus.cpu_stall  = stall_s;
    assign bus.cpu_rvalid = rvalid_r;
    // Present SRAM data in the return cycle itself, the captured copy after
    assign bus.cpu_rdata  = rvalid_r ? bus.DM_DO : rdata_r;
    assign bus.sb_empty   = empty_s;
    assign bus.DM_CS      = dm_cs_s;
    assign bus.DM_OE      = dm_oe_s;
    assign bus.DM_WEB     = dm_web_s;
    assign bus.DM_A       = dm_a_s;
    assign bus.DM_DI      = dm_di_s;

endmodule

// File: tb/tb_dm_store_buffer.sv
// -----------------------------------------------------------------------------
// tb_dm_store_buffer
//
// Drives dm_store_buffer through its interface, models the data SRAM, and
// compares every cycle against a queue-based reference of the buffer plus an
// architectural memory image (what a load must return in program order).
// -----------------------------------------------------------------------------
module tb_dm_store_buffer;
    localparam int DEPTH = 4;
    localparam int AW    = 14;
    localparam int MEMW  = 1 << AW;

    logic clk;
    logic rst;

    dm_store_buffer_if #(.AW(AW)) sb_if ();

    dm_store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sb_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: registered read, byte-masked write
    logic [31:0] sram [MEMW];
    always @(posedge clk) begin
        if (sb_if.DM_CS) begin
            if (sb_if.DM_OE) sb_if.DM_DO <= sram[sb_if.DM_A];
            for (int b = 0; b < 4; b++) begin
                if (!sb_if.DM_WEB[b]) sram[sb_if.DM_A][8*b +: 8] <= sb_if.DM_DI[8*b +: 8];
            end
        end
    end

    // Reference model state
    typedef struct {
        logic [AW-1:0] w;
        logic [3:0]    web;
        logic [31:0]   d;
    } ent_t;
    ent_t        q [$];
    logic [31:0] arch [MEMW];
    logic        exp_rv;
    logic [31:0] exp_rv_data;
    logic [31:0] held_rdata;
    logic        last_stall;

    int errors = 0;
    int checks = 0;

    // Observed outputs of the most recent step (sampled at negedge)
    logic        obs_stall, obs_empty, obs_cs, obs_oe, obs_rv;
    logic [3:0]  obs_web;
    logic [31:0] obs_a, obs_di, obs_rd;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock cycle: drive at posedge+1, check at negedge, advance model
    task automatic step(input logic v, input logic we, input logic [3:0] web,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic drain);
        logic [AW-1:0] word;
        logic e_empty, e_full, e_hit, e_stall, load_go;
        logic e_cs, e_oe;
        logic [3:0] e_web;
        logic [31:0] e_a, e_di;
        ent_t e;
        sb_if.cpu_req_valid = v;
        sb_if.cpu_req_we    = we;
        sb_if.cpu_req_web   = web;
        sb_if.cpu_req_addr  = addr;
        sb_if.cpu_req_wdata = wdata;
        sb_if.drain_req     = drain;
        @(negedge clk);
        word    = addr[AW+1:2];
        e_empty = (q.size() == 0);
        e_full  = (q.size() == DEPTH);
        e_hit   = 1'b0;
        foreach (q[i]) if (q[i].w == word) e_hit = 1'b1;
        e_stall = v && ((drain && !e_empty) || (we && e_full) || (!we && e_hit));
        load_go = v && !we && !e_stall;
        e_cs = 1'b0; e_oe = 1'b0; e_web = 4'hF; e_a = 32'h0; e_di = 32'h0;
        if (load_go) begin
            e_cs = 1'b1; e_oe = 1'b1; e_a = 32'(word);
        end else if (!e_empty) begin
            e_cs = 1'b1; e_web = q[0].web; e_a = 32'(q[0].w); e_di = q[0].d;
        end
        obs_stall = sb_if.cpu_stall;  obs_empty = sb_if.sb_empty;
        obs_cs    = sb_if.DM_CS;      obs_oe    = sb_if.DM_OE;
        obs_web   = sb_if.DM_WEB;     obs_a     = 32'(sb_if.DM_A);
        obs_di    = sb_if.DM_DI;      obs_rv    = sb_if.cpu_rvalid;
        obs_rd    = sb_if.cpu_rdata;
        chk("stall",  32'(obs_stall), 32'(e_stall));
        chk("empty",  32'(obs_empty), 32'(e_empty));
        chk("dm_cs",  32'(obs_cs),    32'(e_cs));
        chk("dm_oe",  32'(obs_oe),    32'(e_oe));
        chk("dm_web", 32'(obs_web),   32'(e_web));
        chk("dm_a",   obs_a,          e_a);
        chk("dm_di",  obs_di,         e_di);
        chk("rvalid", 32'(obs_rv),    32'(exp_rv));
        chk("rdata",  obs_rd,         exp_rv ? exp_rv_data : held_rdata);
        // advance the reference to the state after the coming rising edge
        if (exp_rv) held_rdata = exp_rv_data;
        exp_rv = load_go;
        if (load_go) exp_rv_data = arch[word];
        if (!load_go && !e_empty) void'(q.pop_front());
        if (v && we && !e_stall) begin
            for (int b = 0; b < 4; b++) if (!web[b]) arch[word][8*b +: 8] = wdata[8*b +: 8];
            if (web != 4'hF) begin
                e.w = word; e.web = web; e.d = wdata;
                q.push_back(e);
            end
        end
        last_stall = e_stall;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        sb_if.cpu_req_valid = 1'b0; sb_if.cpu_req_we = 1'b0; sb_if.cpu_req_web = 4'hF;
        sb_if.cpu_req_addr = 32'h0; sb_if.cpu_req_wdata = 32'h0; sb_if.drain_req = 1'b0;
    endtask

    // Asynchronous reset away from the clock edge; pending stores are lost
    task automatic do_reset();
        sb_if.cpu_req_valid = 1'b1; sb_if.cpu_req_we = 1'b0;
        sb_if.cpu_req_addr = 32'h80; sb_if.drain_req = 1'b1;
        rst = 1'b0;
        #1;
        chk("rst_empty",  32'(sb_if.sb_empty),   32'h1);
        chk("rst_stall",  32'(sb_if.cpu_stall),  32'h0);
        chk("rst_web",    32'(sb_if.DM_WEB),     32'hF);
        chk("rst_cs",     32'(sb_if.DM_CS),      32'h0);
        chk("rst_oe",     32'(sb_if.DM_OE),      32'h0);
        chk("rst_a",      32'(sb_if.DM_A),       32'h0);
        chk("rst_di",     sb_if.DM_DI,           32'h0);
        chk("rst_rvalid", 32'(sb_if.cpu_rvalid), 32'h0);
        chk("rst_rdata",  sb_if.cpu_rdata,       32'h0);
        idle_in();
        @(posedge clk);
        @(negedge clk);
        q.delete();
        exp_rv = 1'b0; exp_rv_data = 32'h0; held_rdata = 32'h0; last_stall = 1'b0;
        for (int i = 0; i < MEMW; i++) arch[i] = sram[i];
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic v; logic we; logic [3:0] web; logic [31:0] addr; logic [31:0] wdata; logic drain;
        logic e_stall; logic e_empty; logic e_cs; logic e_oe; logic [3:0] e_web;
        logic [31:0] e_a; logic [31:0] e_di; logic e_rv; logic [31:0] e_rd;
    } vec_t;
    vec_t tab [13];

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic rv, rwe, rdr;
        logic [3:0] rweb;
        logic [31:0] raddr, rwd;

        // store/drain, RAW hazard, byte merge and no-op store, from a clean reset
        tab[0]  = '{1'b1,1'b1,4'h0,32'h10,32'hDEADBEEF,1'b0, 1'b0,1'b1,1'b0,1'b0,4'hF,32'h0, 32'h0,       1'b0,32'h0};
        tab[1]  = '{1'b0,1'b0,4'hF,32'h0, 32'h0,       1'b0, 1'b0,1'b0,1'b1,1'b0,4'h0,32'h4, 32'hDEADBEEF,1'b0,32'h0};
        tab[2]  = '{1'b0,1'b0,4'hF,32'h0, 32'h0,       1'b0, 1'b0,1'b1,1'b0,1'b0,4'hF,32'h0, 32'h0,       1'b0,32'h0};
        tab[3]  = '{1'b1,1'b1,4'h0,32'h20,32'h12345678,1'b0, 1'b0,1'b1,1'b0,1'b0,4'hF,32'h0, 32'h0,       1'b0,32'h0};
        tab[4]  = '{1'b1,1'b0,4'hF,32'h20,32'h0,       1'b0, 1'b1,1'b0,1'b1,1'b0,4'h0,32'h8, 32'h12345678,1'b0,32'h0};
        tab[5]  = '{1'b1,1'b0,4'hF,32'h20,32'h0,       1'b0, 1'b0,1'b1,1'b1,1'b1,4'hF,32'h8, 32'h0,       1'b0,32'h0};
        tab[6]  = '{1'b0,1'b0,4'hF,32'h0, 32'h0,       1'b0, 1'b0,1'b1,1'b0,1'b0,4'hF,32'h0, 32'h0,       1'b1,32'h12345678};
        tab[7]  = '{1'b0,1'b0,4'hF,32'h0, 32'h0,       1'b0, 1'b0,1'b1,1'b0,1'b0,4'hF,32'h0, 32'h0,       1'b0,32'h12345678};
        tab[8]  = '{1'b1,1'b1,4'h0,32'h40,32'hAABBCCDD,1'b0, 1'b0,1'b1,1'b0,1'b0,4'hF,32'h0, 32'h0,       1'b0,32'h12345678};
        tab[9]  = '{1'b1,1'b1,4'hE,32'h40,32'h000000EE,1'b0, 1'b0,1'b0,1'b1,1'b0,4'h0,32'h10,32'hAABBCCDD,1'b0,32'h12345678};
        tab[10] = '{1'b1,1'b1,4'hF,32'h44,32'h00000055,1'b0, 1'b0,1'b0,1'b1,1'b0,4'hE,32'h10,32'h000000EE,1'b0,32'h12345678};
        tab[11] = '{1'b1,1'b0,4'hF,32'h40,32'h0,       1'b0, 1'b0,1'b1,1'b1,1'b1,4'hF,32'h10,32'h0,       1'b0,32'h12345678};
        tab[12] = '{1'b0,1'b0,4'hF,32'h0, 32'h0,       1'b0, 1'b0,1'b1,1'b0,1'b0,4'hF,32'h0, 32'h0,       1'b1,32'hAABBCCEE};

        for (int i = 0; i < MEMW; i++) sram[i] = 32'h0;
        sb_if.DM_DO = 32'h0;
        idle_in();
        rst = 1'b1;
        #1;
        do_reset();

        for (int i = 0; i < 13; i++) begin
            step(tab[i].v, tab[i].we, tab[i].web, tab[i].addr, tab[i].wdata, tab[i].drain);
            chk("tab_stall",  32'(obs_stall), 32'(tab[i].e_stall));
            chk("tab_empty",  32'(obs_empty), 32'(tab[i].e_empty));
            chk("tab_cs",     32'(obs_cs),    32'(tab[i].e_cs));
            chk("tab_oe",     32'(obs_oe),    32'(tab[i].e_oe));
            chk("tab_web",    32'(obs_web),   32'(tab[i].e_web));
            chk("tab_a",      obs_a,          tab[i].e_a);
            chk("tab_di",     obs_di,         tab[i].e_di);
            chk("tab_rvalid", 32'(obs_rv),    32'(tab[i].e_rv));
            chk("tab_rdata",  obs_rd,         tab[i].e_rd);
        end

        // Fence: pending store, drain_req with a load presented
        step(1'b1, 1'b1, 4'h0, 32'h100, 32'hCAFEF00D, 1'b0);
        step(1'b1, 1'b0, 4'hF, 32'h200, 32'h0, 1'b1);
        chk("fence_stall", 32'(obs_stall), 32'h1);
        chk("fence_drain", 32'(obs_cs & ~obs_oe), 32'h1);
        step(1'b1, 1'b0, 4'hF, 32'h200, 32'h0, 1'b1);
        chk("fence_go", 32'(obs_stall), 32'h0);
        chk("fence_load_a", obs_a, 32'h80);
        step(1'b1, 1'b0, 4'hF, 32'h100, 32'h0, 1'b1);
        chk("fence_empty_nostall", 32'(obs_stall), 32'h0);
        step(1'b0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0);
        chk("fence_rdata", obs_rd, 32'hCAFEF00D);

        // Reset while a store is draining: it must never reach SRAM
        step(1'b1, 1'b1, 4'h0, 32'h80, 32'h11112222, 1'b0);
        do_reset();
        step(1'b0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0);
        chk("rst_no_write", 32'(obs_cs), 32'h0);
        step(1'b1, 1'b0, 4'hF, 32'h80, 32'h0, 1'b0);
        step(1'b0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0);
        chk("rst_discard", obs_rd, 32'h0);

        // Randomized traffic; a stalled request is held stable
        last_stall = 1'b0;
        rv = 1'b0; rwe = 1'b0; rdr = 1'b0; rweb = 4'hF; raddr = 32'h0; rwd = 32'h0;
        for (int n = 0; n < 3000; n++) begin
            if (n % 1000 == 999) do_reset();
            if (!last_stall) begin
                rv    = ($urandom_range(0, 3) != 0);
                rwe   = 1'($urandom_range(0, 1));
                rweb  = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom);
                raddr = ($urandom & 32'hFFFF_0003) | (32'($urandom_range(0, 7)) << 2);
                rwd   = $urandom;
                rdr   = ($urandom_range(0, 7) == 0);
            end
            step(rv, rwe, rweb, raddr, rwd, rdr);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
